// File: rtl/registered_channel_mux.sv
// N-to-1 channel multiplexer with a single output register, fixed-select or
// round-robin arbitration, and a running count of input transfers.
module registered_channel_mux #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned SELW     = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      mode,
   input  logic [SELW-1:0]           sel,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SELW-1:0]           out_chan,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [15:0]               xfer_count
);

   localparam int unsigned CNT_W = 16;

   logic [WIDTH-1:0]      out_data_q,  out_data_d;
   logic [SELW-1:0]       out_chan_q,  out_chan_d;
   logic                  out_valid_q, out_valid_d;
   logic [SELW-1:0]       ptr_q,       ptr_d;
   logic [CNT_W-1:0]      cnt_q,       cnt_d;

   logic                  load_ok_c;
   logic                  grant_vld_c;
   logic [SELW-1:0]       grant_c;
   logic                  rr_hit_c;
   logic [2*CHANNELS-1:0] rot_c;
   logic [WIDTH-1:0]      grant_data_c;
   logic                  xfer_c;

   assign load_ok_c = !out_valid_q || out_ready;

   // Rotating the doubled valid vector by ptr turns the wrap-around search into a lowest-bit search.
   always_comb begin
      grant_vld_c = 1'b0;
      grant_c     = '0;
      rr_hit_c    = 1'b0;
      rot_c       = {in_valid, in_valid} >> ptr_q;
      if (!mode) begin
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (sel == SELW'(k) && in_valid[k]) begin
               grant_vld_c = 1'b1;
               grant_c     = SELW'(k);
            end
         end
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (!rr_hit_c && rot_c[i]) begin
               rr_hit_c    = 1'b1;
               grant_vld_c = 1'b1;
               grant_c     = SELW'((32'(ptr_q) + i) % CHANNELS);
            end
         end
      end
   end

   // Ready goes only to the granted channel, and never while reset is held.
   always_comb begin
      in_ready     = '0;
      grant_data_c = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (grant_c == SELW'(k)) begin
            in_ready[k]  = grant_vld_c && load_ok_c && !reset;
            grant_data_c = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   assign xfer_c = grant_vld_c && load_ok_c && !reset;

   always_comb begin
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      if (xfer_c) begin
         out_data_d  = grant_data_c;
         out_chan_d  = grant_c;
         out_valid_d = 1'b1;
         ptr_d       = SELW'((32'(grant_c) + 32'd1) % CHANNELS);
         cnt_d       = cnt_q + CNT_W'(1);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
         cnt_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_data   = out_data_q;
   assign out_chan   = out_chan_q;
   assign out_valid  = out_valid_q;
   assign xfer_count = cnt_q;

endmodule

// File: tb/tb_registered_channel_mux.sv
// Directed bench for registered_channel_mux: stimulus pushes expected words into
// a queue and a negedge monitor pops and compares each delivered word.
module tb_registered_channel_mux;

   logic        clk = 1'b0;
   logic        reset;

   logic        mode;
   logic [1:0]  sel;
   logic [127:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [31:0] out_data;
   logic [1:0]  out_chan;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] xfer_count;

   logic        mode3;
   logic [1:0]  sel3;
   logic [23:0] in_data3;
   logic [2:0]  in_valid3;
   logic [2:0]  in_ready3;
   logic [7:0]  out_data3;
   logic [1:0]  out_chan3;
   logic        out_valid3;
   logic        out_ready3;
   logic [15:0] xfer_count3;

   typedef struct {
      logic [1:0]  chan;
      logic [31:0] data;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   n_xfer = 0;

   localparam logic [127:0] RR_DATA = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};

   always #5 clk = ~clk;

   registered_channel_mux #(.WIDTH(32), .CHANNELS(4), .SELW(2)) u4 (
      .clk(clk), .reset(reset), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
      .out_ready(out_ready), .xfer_count(xfer_count)
   );

   registered_channel_mux #(.WIDTH(8), .CHANNELS(3), .SELW(2)) u3 (
      .clk(clk), .reset(reset), .mode(mode3), .sel(sel3),
      .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
      .out_ready(out_ready3), .xfer_count(xfer_count3)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] chan, input logic [31:0] data);
      exp_t e;
      n_xfer++;
      e.chan = chan;
      e.data = data;
      e.cnt  = 16'(n_xfer);
      q.push_back(e);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = '0;
      in_valid3 = '0;
      step();
      step();
      reset  = 1'b0;
      n_xfer = 0;
   endtask

   // Every word accepted downstream must match the head of the expected queue.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("sb_unexpected_word", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_data", 64'(out_data), 64'(e.data));
            chk("sb_chan", 64'(out_chan), 64'(e.chan));
            chk("sb_count", 64'(xfer_count), 64'(e.cnt));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; mode = 1'b1; sel = '0; in_data = RR_DATA; in_valid = 4'hF; out_ready = 1'b1;
      mode3 = 1'b0; sel3 = '0; in_data3 = '0; in_valid3 = '0; out_ready3 = 1'b0;

      // Reset values and in_ready forced low while reset is held.
      #1 reset = 1'b1;
      #2;
      chk("rst_in_ready", 64'(in_ready), 64'h0);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_data", 64'(out_data), 64'h0);
      chk("rst_out_chan", 64'(out_chan), 64'h0);
      chk("rst_xfer_count", 64'(xfer_count), 64'h0);

      // Round-robin over all four channels.
      do_reset();
      mode = 1'b1; in_data = RR_DATA; in_valid = 4'hF; out_ready = 1'b1;
      #1 chk("rr_first_ready", 64'(in_ready), 64'b0001);
      push(2'd0, 32'hA000_0000);
      push(2'd1, 32'hA000_0001);
      push(2'd2, 32'hA000_0002);
      push(2'd3, 32'hA000_0003);
      push(2'd0, 32'hA000_0000);
      repeat (5) step();
      in_valid = '0;
      chk("rr_xfer_count", 64'(xfer_count), 64'd5);
      step();
      step();
      chk("rr_idle_valid", 64'(out_valid), 64'h0);

      // Fixed select of channel 1.
      do_reset();
      mode = 1'b0; sel = 2'd1; in_data = {32'h4, 32'h3, 32'h2, 32'h1}; in_valid = 4'hF; out_ready = 1'b1;
      #1 chk("fixed_ready", 64'(in_ready), 64'b0010);
      push(2'd1, 32'h2);
      step();
      in_valid = '0;
      chk("fixed_out_data", 64'(out_data), 64'h2);
      chk("fixed_xfer_count", 64'(xfer_count), 64'd1);
      step();
      step();

      // Back-pressure: hold three cycles, then drain and reload in one edge.
      do_reset();
      mode = 1'b0; sel = 2'd2; in_data = {32'h0, 32'h2222_0001, 32'h0, 32'h0};
      in_valid = 4'b0100; out_ready = 1'b0;
      push(2'd2, 32'h2222_0001);
      step();
      in_data = {32'h0, 32'h2222_0002, 32'h0, 32'h0};
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_hold_ready", 64'(in_ready), 64'h0);
         chk("bp_hold_valid", 64'(out_valid), 64'h1);
         chk("bp_hold_data", 64'(out_data), 64'h2222_0001);
         step();
      end
      out_ready = 1'b1;
      push(2'd2, 32'h2222_0002);
      #1 chk("bp_release_ready", 64'(in_ready), 64'b0100);
      step();
      chk("bp_no_bubble", 64'(out_valid), 64'h1);
      chk("bp_reload_data", 64'(out_data), 64'h2222_0002);
      in_valid = '0;
      step();
      chk("bp_drained_valid", 64'(out_valid), 64'h0);
      chk("bp_drained_data_kept", 64'(out_data), 64'h2222_0002);
      chk("bp_drained_chan_kept", 64'(out_chan), 64'd2);

      // Sparse round-robin with channels 1 and 3 valid.
      do_reset();
      mode = 1'b1; in_data = RR_DATA; in_valid = 4'b1010; out_ready = 1'b1;
      #1 chk("sparse_first_ready", 64'(in_ready), 64'b0010);
      push(2'd1, 32'hA000_0001);
      push(2'd3, 32'hA000_0003);
      push(2'd1, 32'hA000_0001);
      repeat (3) step();
      in_valid = '0;
      step();
      step();

      // Out-of-range select on a three-channel instance.
      mode3 = 1'b0; sel3 = 2'd3; in_data3 = {8'h33, 8'h22, 8'h11}; in_valid3 = 3'b111; out_ready3 = 1'b1;
      #1 chk("oor_ready", 64'(in_ready3), 64'h0);
      step();
      step();
      chk("oor_out_valid", 64'(out_valid3), 64'h0);
      chk("oor_xfer_count", 64'(xfer_count3), 64'h0);
      sel3 = 2'd2;
      #1 chk("c3_sel2_ready", 64'(in_ready3), 64'b100);
      step();
      in_valid3 = '0;
      chk("c3_out_valid", 64'(out_valid3), 64'h1);
      chk("c3_out_chan", 64'(out_chan3), 64'd2);
      chk("c3_out_data", 64'(out_data3), 64'h33);

      // Asynchronous reset while a word is held; restart from pointer 0.
      do_reset();
      mode = 1'b1; in_data = RR_DATA; in_valid = 4'hF; out_ready = 1'b0;
      step();
      chk("mid_pre_valid", 64'(out_valid), 64'h1);
      #1 reset = 1'b1;
      #1;
      chk("mid_async_valid", 64'(out_valid), 64'h0);
      chk("mid_async_data", 64'(out_data), 64'h0);
      chk("mid_async_chan", 64'(out_chan), 64'h0);
      chk("mid_async_count", 64'(xfer_count), 64'h0);
      chk("mid_async_ready", 64'(in_ready), 64'h0);
      step();
      reset = 1'b0; n_xfer = 0; out_ready = 1'b1;
      #1 chk("mid_restart_ready", 64'(in_ready), 64'b0001);
      push(2'd0, 32'hA000_0000);
      step();
      in_valid = '0;
      step();
      step();

      chk("sb_queue_empty", 64'(q.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/registered_channel_mux.md
REGISTERED_CHANNEL_MUX -- requirements
Module: registered_channel_mux

Interface
- REQ-001 SHALL have parameter WIDTH, default 32: data bits per channel.
- REQ-002 SHALL have parameter CHANNELS, default 4: number of input channels; legal values 2..16.
- REQ-003 SHALL have parameter SELW, default 2: select/index width; SELW = ceil(log2(CHANNELS)).
- REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
- REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
- REQ-006 SHALL have port mode, input, 1: 0 = fixed select, 1 = round-robin.
- REQ-007 SHALL have port sel, input, SELW: channel index used in fixed mode.
- REQ-008 SHALL have port in_data, input, CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- REQ-009 SHALL have port in_valid, input, CHANNELS: per-channel valid.
- REQ-010 SHALL have port in_ready, output, CHANNELS: per-channel ready, combinational.
- REQ-011 SHALL have port out_data, output, WIDTH: registered output word.
- REQ-012 SHALL have port out_chan, output, SELW: index of the channel that supplied out_data.
- REQ-013 SHALL have port out_valid, output, 1: out_data holds an undelivered word.
- REQ-014 SHALL have port out_ready, input, 1: downstream accepts the word.
- REQ-015 SHALL have port xfer_count, output, 16: number of input transfers since reset, wrapping.

Function
- REQ-016 SHALL define load_ok = !out_valid || out_ready, giving single-register storage with full throughput.
- REQ-017 SHALL, in fixed mode, grant channel sel when sel < CHANNELS and in_valid[sel] = 1; otherwise no grant.
- REQ-018 SHALL, in round-robin mode, grant the first valid channel searching upward from pointer ptr and wrapping at CHANNELS-1 to 0; no grant if in_valid is all zero.
- REQ-019 SHALL drive in_ready[grant] = load_ok and every other in_ready bit 0; all in_ready bits are 0 when there is no grant.
- REQ-020 SHALL define an input transfer as in_valid[g] && in_ready[g]; on the following edge out_data <= channel g data, out_chan <= g, out_valid <= 1.
- REQ-021 SHALL have a latency of exactly 1 clk from input transfer to out_valid/out_data visible.
- REQ-022 SHALL, on out_valid && out_ready with no input transfer in the same cycle, clear out_valid on the next edge, leaving out_data and out_chan unchanged.
- REQ-023 SHALL, when an output drain and an input transfer occur in the same cycle, load the new word with out_valid staying 1 (no bubble).
- REQ-024 SHALL hold out_data, out_chan and out_valid stable while out_valid && !out_ready.
- REQ-025 SHALL, on every input transfer in either mode, update ptr <= g+1, with g = CHANNELS-1 wrapping ptr to 0.
- REQ-026 SHALL leave ptr unchanged when mode changes; the new mode applies to the grant in the same cycle.
- REQ-027 SHALL increment xfer_count by 1 per input transfer, wrapping 0xFFFF -> 0x0000.
- REQ-028 SHALL grant nothing when sel >= CHANNELS (non-power-of-2 CHANNELS) in fixed mode; this is not an error.

Reset
- REQ-029 SHALL, while reset = 1, asynchronously force out_valid = 0, out_data = 0, out_chan = 0, ptr = 0 and xfer_count = 0.
- REQ-030 SHALL drive all in_ready bits to 0 while reset = 1.
- REQ-031 SHALL discard a held word when reset is asserted mid-operation; the first grant after release starts from ptr = 0.

Verification
- REQ-032 SHALL be checked for fixed mode (WIDTH=32, CHANNELS=4): mode=0, sel=1, ch0=0x1, ch1=0x2, all valid, out_ready=1 -> in_ready=0010; next cycle out_data=0x2, out_chan=1, xfer_count=1.
- REQ-033 SHALL be checked for round-robin order: mode=1, in_valid=1111, out_ready=1 for 5 cycles -> out_chan sequence 0,1,2,3,0 and xfer_count=5.
- REQ-034 SHALL be checked for back-pressure: out_valid=1 with out_ready=0 for 3 cycles -> in_ready=0000 and out_data stable; then out_ready=1 -> drain and a new load occur in the same cycle, out_valid stays 1.
- REQ-035 SHALL be checked for sparse round-robin: in_valid=1010, ptr=0 -> grant 1, then grant 3, then grant 1.
- REQ-036 SHALL be checked for out-of-range select: CHANNELS=3, mode=0, sel=3 -> in_ready=000 and out_valid stays 0.
- REQ-037 SHALL be checked for reset mid-operation: assert reset between clk edges while out_valid=1 -> outputs go to 0 immediately without a clk edge; after release with in_valid=1111 and mode=1 -> first out_chan=0.
